// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder for the CVA6 LSU shim/model.
// Loads and stores are accepted into two independent in-order queues. Each entry
// counts down from its channel latency and fires a one-cycle completion pulse,
// with its address, when it reaches the head of the queue and its countdown is zero.

// Per-channel in-order latency queue.
// Each slot holds {valid, addr, countdown}. Every valid slot counts down in
// parallel, so the head is due as soon as its own countdown reaches zero.
module cva6_lsu_mem_responder_q #(
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 2,
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_full,
  output logic [OCC_W-1:0]  o_count,
  output logic              o_resp,
  output logic [ADDR_W-1:0] o_resp_addr
);

  logic              r_vld  [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [CNT_W-1:0]  r_cnt  [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [OCC_W-1:0]  r_count;

  logic w_push;
  logic w_pop;
  logic w_head_due;

  // Pointer advance with explicit wrap so DEPTH=1 also works.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (DEPTH == 1) begin
      n = '0;
    end else if (p == PTR_W'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Head is due when it is occupied and its countdown has expired.
  always_comb begin
    w_head_due = r_vld[r_rd] && (r_cnt[r_rd] == '0);
    w_pop      = w_head_due;
    w_push     = i_push && !o_full;
  end

  // Full / occupancy come from registered state only.
  always_comb begin
    o_full  = (r_count == OCC_W'(DEPTH));
    o_count = r_count;
  end

  // Response address is forced to zero whenever no pulse is issued.
  always_comb begin
    o_resp      = w_head_due;
    o_resp_addr = w_head_due ? r_addr[r_rd] : '0;
  end

  // Slot storage, parallel countdown, pointer and occupancy update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
      if (w_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= f_inc(r_rd);
      end
      // A push never lands on the popped slot: push requires !full, and the
      // popped slot is the head, which is only the write slot when full.
      if (w_push) begin
        r_vld[r_wr]  <= 1'b1;
        r_addr[r_wr] <= i_addr;
        r_cnt[r_wr]  <= CNT_W'(LATENCY - 1);
        r_wr         <= f_inc(r_wr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// Top level: routes accepted requests to the load or store queue and keeps
// the sticky overflow flag for requests presented while not ready.
module cva6_lsu_mem_responder #(
  parameter int ADDR_W        = 32,
  parameter int LOAD_LATENCY  = 3,
  parameter int STORE_LATENCY = 2,
  parameter int DEPTH         = 2,
  localparam int OCC_W        = $clog2(DEPTH + 1),
  localparam int OUT_W        = $clog2(2 * DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_is_load_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              ready_o,
  output logic              load_mem_resp_o,
  output logic [ADDR_W-1:0] load_resp_addr_o,
  output logic              store_mem_resp_o,
  output logic [ADDR_W-1:0] store_resp_addr_o,
  output logic [OUT_W-1:0]  outstanding_o,
  output logic              overflow_o
);

  logic             w_ld_full;
  logic             w_st_full;
  logic [OCC_W-1:0] w_ld_count;
  logic [OCC_W-1:0] w_st_count;
  logic             w_ready;
  logic             w_accept;
  logic             w_ld_push;
  logic             w_st_push;
  logic             r_overflow;

  // Readiness uses registered fullness only; a same-cycle pop does not help.
  always_comb begin
    w_ready   = !w_ld_full && !w_st_full;
    w_accept  = req_valid_i && w_ready;
    w_ld_push = w_accept && req_is_load_i;
    w_st_push = w_accept && !req_is_load_i;
  end

  cva6_lsu_mem_responder_q #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LOAD_LATENCY),
    .DEPTH   (DEPTH)
  ) u_load_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_ld_push),
    .i_addr      (req_addr_i),
    .o_full      (w_ld_full),
    .o_count     (w_ld_count),
    .o_resp      (load_mem_resp_o),
    .o_resp_addr (load_resp_addr_o)
  );

  cva6_lsu_mem_responder_q #(
    .ADDR_W  (ADDR_W),
    .LATENCY (STORE_LATENCY),
    .DEPTH   (DEPTH)
  ) u_store_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_st_push),
    .i_addr      (req_addr_i),
    .o_full      (w_st_full),
    .o_count     (w_st_count),
    .o_resp      (store_mem_resp_o),
    .o_resp_addr (store_resp_addr_o)
  );

  // Sticky overflow: a dropped request is remembered until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else if (req_valid_i && !w_ready) begin
      r_overflow <= 1'b1;
    end
  end

  // Output assembly.
  always_comb begin
    ready_o       = w_ready;
    outstanding_o = OUT_W'(w_ld_count) + OUT_W'(w_st_count);
    overflow_o    = r_overflow;
  end

endmodule
